// File: rtl/handle_guess_master.sv
// Master-side guess handler: validates the local BCD entry, marks the circle bitmap and
// sends SEL_NUM / STATE_WIN over a req/ack link. Optional ack-timeout retry via GUESS_TX_RETRY_EN.
module handle_guess_master #(
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         interboard_rst,
    input  logic [3:0]   cur_game_state,
    input  logic         start_guess,
    input  logic         clear_guess,
    input  logic [7:0]   cur_number_BCD,
    input  logic         enter_pulse,
    input  logic [124:0] num_to_pos,
    input  logic         win_pulse,
    input  logic         tx_ack,
    output logic         tx_req,
    output logic [2:0]   tx_msg_type,
    output logic [4:0]   tx_number,
    output logic         guess_done,
    output logic         link_err,
    output logic [24:0]  circle
);

    // Encodings shared with slave_game_macro.v / message_macro.v
    localparam logic [3:0] GAME_P1_GUESS = 4'd2;
    localparam logic [2:0] SEL_NUM       = 3'd1;
    localparam logic [2:0] STATE_WIN     = 3'd5;

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        WAIT_PLAYER_IN = 3'd1,
        SEND           = 3'd2,
        WAIT_GAP       = 3'd3,
        FIN            = 3'd4
    } state_t;

    state_t       state_r, next_state_s;
    logic [6:0]   cur_number_s;
    logic [4:0]   pos_s;
    logic [31:0]  circle_ext_s;
    logic         valid_s, accept_guess_s, accept_win_s;
    logic         tx_req_d_s, guess_done_d_s, link_err_d_s;
    logic         tx_req_r, guess_done_r, link_err_r;
    logic [2:0]   msg_type_r;
    logic [4:0]   number_r;
    logic [24:0]  circle_r;

`ifdef GUESS_TX_RETRY_EN
    localparam logic [31:0] TO_LAST   = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] RETRY_MAX = 32'(MAX_RETRY);
    logic [31:0] timeout_cnt_r, retry_cnt_r;
    logic        timeout_s;
    assign timeout_s = (state_r == SEND) && !tx_ack && (timeout_cnt_r == TO_LAST);
`endif

    // 7-bit value wraps for non-BCD digits; such wrapped values are still range-checked
    assign cur_number_s = ({3'b000, cur_number_BCD[7:4]} * 7'd10) + {3'b000, cur_number_BCD[3:0]};
    assign circle_ext_s = {7'd0, circle_r};

    // Board position lookup for the entered number
    always_comb begin
        pos_s = 5'd0;
        for (int n = 1; n <= 25; n++) begin
            if (cur_number_s == 7'(n)) begin
                pos_s = num_to_pos[5*n-1 -: 5];
            end else begin
                pos_s = pos_s;
            end
        end
    end

    assign valid_s        = (cur_number_s >= 7'd1) && (cur_number_s <= 7'd25) && !circle_ext_s[pos_s];
    assign accept_win_s   = (state_r == WAIT_PLAYER_IN) && win_pulse;
    assign accept_guess_s = (state_r == WAIT_PLAYER_IN) && !win_pulse && enter_pulse &&
                            (cur_game_state == GAME_P1_GUESS) && valid_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else if (interboard_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_guess) next_state_s = WAIT_PLAYER_IN;
                else             next_state_s = IDLE;
            end
            WAIT_PLAYER_IN: begin
                if (accept_win_s || accept_guess_s) next_state_s = SEND;
                else                                next_state_s = WAIT_PLAYER_IN;
            end
            SEND: begin
                if (tx_ack) begin
                    next_state_s = (msg_type_r == SEL_NUM) ? FIN : IDLE;
`ifdef GUESS_TX_RETRY_EN
                end else if (timeout_s) begin
                    next_state_s = (retry_cnt_r == RETRY_MAX) ? IDLE : WAIT_GAP;
`endif
                end else begin
                    next_state_s = SEND;
                end
            end
            WAIT_GAP: next_state_s = SEND;
            FIN:      next_state_s = IDLE;
            default:  next_state_s = IDLE;
        endcase
    end

    // Output decode; the values are registered so they line up with the new state
    always_comb begin
        tx_req_d_s     = (next_state_s == SEND);
        guess_done_d_s = (next_state_s == FIN);
`ifdef GUESS_TX_RETRY_EN
        link_err_d_s   = timeout_s && (retry_cnt_r == RETRY_MAX);
`else
        link_err_d_s   = 1'b0;
`endif
    end

    // Registered outputs, latched message and circle bitmap
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_req_r     <= 1'b0;
            guess_done_r <= 1'b0;
            link_err_r   <= 1'b0;
            msg_type_r   <= 3'd0;
            number_r     <= 5'd0;
            circle_r     <= 25'd0;
        end else if (interboard_rst) begin
            tx_req_r     <= 1'b0;
            guess_done_r <= 1'b0;
            link_err_r   <= 1'b0;
            msg_type_r   <= 3'd0;
            number_r     <= 5'd0;
            circle_r     <= 25'd0;
        end else begin
            tx_req_r     <= tx_req_d_s;
            guess_done_r <= guess_done_d_s;
            link_err_r   <= link_err_d_s;
            if (accept_win_s) begin
                msg_type_r <= STATE_WIN;
                number_r   <= 5'd0;
            end else if (accept_guess_s) begin
                msg_type_r <= SEL_NUM;
                number_r   <= cur_number_s[4:0];
            end else begin
                msg_type_r <= msg_type_r;
                number_r   <= number_r;
            end
            // Clear wins over a same-cycle mark
            if (clear_guess) begin
                circle_r <= 25'd0;
            end else if (accept_guess_s && (pos_s < 5'd25)) begin
                circle_r[pos_s] <= 1'b1;
            end else begin
                circle_r <= circle_r;
            end
        end
    end

`ifdef GUESS_TX_RETRY_EN
    // Ack timeout and retry counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_cnt_r <= 32'd0;
            retry_cnt_r   <= 32'd0;
        end else if (interboard_rst) begin
            timeout_cnt_r <= 32'd0;
            retry_cnt_r   <= 32'd0;
        end else begin
            if ((state_r != SEND) || tx_ack) timeout_cnt_r <= 32'd0;
            else                             timeout_cnt_r <= timeout_cnt_r + 32'd1;
            if ((state_r == SEND) && tx_ack)  retry_cnt_r <= 32'd0;
            else if (timeout_s)               retry_cnt_r <= (retry_cnt_r == RETRY_MAX) ? 32'd0 : retry_cnt_r + 32'd1;
            else if (state_r == IDLE)         retry_cnt_r <= 32'd0;
            else                              retry_cnt_r <= retry_cnt_r;
        end
    end
`endif

    assign tx_req      = tx_req_r;
    assign tx_msg_type = msg_type_r;
    assign tx_number   = number_r;
    assign guess_done  = guess_done_r;
    assign link_err    = link_err_r;
    assign circle      = circle_r;

endmodule

// File: tb/tb_handle_guess_master.sv
// Directed bench for handle_guess_master with a message scoreboard.
// Retry scenarios run only when GUESS_TX_RETRY_EN is defined.
module tb_handle_guess_master;

    localparam logic [3:0] GAME_WAIT_P1_GUESS = 4'd1;
    localparam logic [3:0] GAME_P1_GUESS      = 4'd2;
    localparam logic [2:0] SEL_NUM            = 3'd1;
    localparam logic [2:0] STATE_WIN          = 3'd5;

    typedef struct packed {
        logic [2:0] mtype;
        logic [4:0] num;
    } msg_t;

    logic         clk, rst, interboard_rst;
    logic [3:0]   cur_game_state;
    logic         start_guess, clear_guess, enter_pulse, win_pulse, tx_ack;
    logic [7:0]   cur_number_BCD;
    logic [124:0] num_to_pos;
    logic         tx_req, guess_done, link_err;
    logic [2:0]   tx_msg_type;
    logic [4:0]   tx_number;
    logic [24:0]  circle;

    int   tests = 0;
    int   fails = 0;
    msg_t sb_q[$];
    logic [24:0] exp_circle;

    handle_guess_master #(.ACK_TIMEOUT(8), .MAX_RETRY(3)) dut (
        .clk(clk), .rst(rst), .interboard_rst(interboard_rst),
        .cur_game_state(cur_game_state), .start_guess(start_guess),
        .clear_guess(clear_guess), .cur_number_BCD(cur_number_BCD),
        .enter_pulse(enter_pulse), .num_to_pos(num_to_pos),
        .win_pulse(win_pulse), .tx_ack(tx_ack), .tx_req(tx_req),
        .tx_msg_type(tx_msg_type), .tx_number(tx_number),
        .guess_done(guess_done), .link_err(link_err), .circle(circle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [4:0] pos_of(input int n);
        return 5'((n + 12) % 25);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Pop the expected message and compare against what is on the link
    task automatic check_msg(input string tag);
        msg_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_req"},  32'(tx_req), 32'd1);
            chk({tag, "_type"}, 32'(tx_msg_type), 32'(e.mtype));
            chk({tag, "_num"},  32'(tx_number), 32'(e.num));
        end
    endtask

    task automatic enter_bcd(input logic [7:0] bcd);
        cur_number_BCD = bcd;
        enter_pulse    = 1'b1;
        cyc();
        enter_pulse    = 1'b0;
    endtask

    task automatic arm();
        start_guess = 1'b1;
        cyc();
        start_guess = 1'b0;
    endtask

    task automatic ack_guess(input string tag);
        tx_ack = 1'b1;
        cyc();
        tx_ack = 1'b0;
        chk({tag, "_done"}, 32'(guess_done), 32'd1);
        chk({tag, "_req_low"}, 32'(tx_req), 32'd0);
        cyc();
        chk({tag, "_done_pulse"}, 32'(guess_done), 32'd0);
    endtask

    initial begin
        logic [7:0] bad_bcd [3];
        bad_bcd[0] = 8'h00; bad_bcd[1] = 8'h26; bad_bcd[2] = 8'h17;

        rst = 1'b0; interboard_rst = 1'b0; cur_game_state = GAME_P1_GUESS;
        start_guess = 1'b0; clear_guess = 1'b0; enter_pulse = 1'b0;
        win_pulse = 1'b0; tx_ack = 1'b0; cur_number_BCD = 8'h00;
        for (int n = 1; n <= 25; n++) num_to_pos[5*n-1 -: 5] = pos_of(n);
        exp_circle = 25'd0;

        cyc(); cyc();
        chk("rst_req", 32'(tx_req), 32'd0);
        chk("rst_type", 32'(tx_msg_type), 32'd0);
        chk("rst_num", 32'(tx_number), 32'd0);
        chk("rst_done", 32'(guess_done), 32'd0);
        chk("rst_lerr", 32'(link_err), 32'd0);
        chk("rst_circle", 32'(circle), 32'd0);
        rst = 1'b1;
        cyc();

        // Basic guess of 17 (position 4)
        arm();
        sb_q.push_back('{SEL_NUM, 5'd17});
        exp_circle[pos_of(17)] = 1'b1;
        enter_bcd(8'h17);
        check_msg("basic");
        chk("basic_circle", 32'(circle), 32'(exp_circle));
        chk("basic_pos4", 32'(circle[4]), 32'd1);
        enter_bcd(8'h22);
        chk("send_hold_num", 32'(tx_number), 32'd17);
        chk("send_hold_circle", 32'(circle), 32'(exp_circle));
        ack_guess("basic");

        // Invalid entries ignored, then 05 accepted
        arm();
        for (int i = 0; i < 3; i++) begin
            enter_bcd(bad_bcd[i]);
            chk($sformatf("invalid_%0h_req", bad_bcd[i]), 32'(tx_req), 32'd0);
            chk($sformatf("invalid_%0h_circle", bad_bcd[i]), 32'(circle), 32'(exp_circle));
        end
        sb_q.push_back('{SEL_NUM, 5'd5});
        exp_circle[pos_of(5)] = 1'b1;
        enter_bcd(8'h05);
        check_msg("valid05");
        chk("valid05_circle", 32'(circle), 32'(exp_circle));
        ack_guess("valid05");

        // Win message: no guess_done
        arm();
        sb_q.push_back('{STATE_WIN, 5'd0});
        win_pulse = 1'b1;
        cyc();
        win_pulse = 1'b0;
        check_msg("win");
        tx_ack = 1'b1;
        cyc();
        tx_ack = 1'b0;
        chk("win_req_low", 32'(tx_req), 32'd0);
        chk("win_no_done", 32'(guess_done), 32'd0);
        cyc();
        chk("win_no_done2", 32'(guess_done), 32'd0);
        enter_bcd(8'h11);
        chk("win_idle_req", 32'(tx_req), 32'd0);

        // Clear has priority over same-cycle mark
        arm();
        sb_q.push_back('{SEL_NUM, 5'd9});
        exp_circle = 25'd0;
        clear_guess = 1'b1;
        enter_bcd(8'h09);
        clear_guess = 1'b0;
        check_msg("clr");
        chk("clr_circle", 32'(circle), 32'd0);

        // Async reset during SEND
        #2 rst = 1'b0;
        #1;
        chk("async_rst_req", 32'(tx_req), 32'd0);
        cyc();
        rst = 1'b1;
        cyc();

        // Wrong game state: enter ignored; link reset returns to IDLE
        arm();
        cur_game_state = GAME_WAIT_P1_GUESS;
        enter_bcd(8'h12);
        chk("wrongstate_req", 32'(tx_req), 32'd0);
        chk("wrongstate_circle", 32'(circle), 32'd0);
        cur_game_state = GAME_P1_GUESS;
        interboard_rst = 1'b1;
        cyc();
        interboard_rst = 1'b0;
        enter_bcd(8'h12);
        chk("ibrst_idle_req", 32'(tx_req), 32'd0);
        tx_ack = 1'b1;
        cyc();
        tx_ack = 1'b0;
        chk("idle_ack_req", 32'(tx_req), 32'd0);
        chk("idle_ack_done", 32'(guess_done), 32'd0);

        // interboard_rst mid-SEND clears everything
        arm();
        sb_q.push_back('{SEL_NUM, 5'd21});
        enter_bcd(8'h21);
        check_msg("ib");
        chk("ib_circle_set", 32'(circle), 32'(25'd1 << pos_of(21)));
        interboard_rst = 1'b1;
        cyc();
        interboard_rst = 1'b0;
        chk("ib_req", 32'(tx_req), 32'd0);
        chk("ib_circle", 32'(circle), 32'd0);

`ifdef GUESS_TX_RETRY_EN
        // No ack: 8 cycles of req, 1 gap, link_err after the 4th timeout
        arm();
        sb_q.push_back('{SEL_NUM, 5'd3});
        enter_bcd(8'h03);
        check_msg("rty");
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 8; j++) begin
                chk($sformatf("rty_req_%0d_%0d", k, j), 32'(tx_req), 32'd1);
                cyc();
            end
            chk($sformatf("rty_gap_%0d", k), 32'(tx_req), 32'd0);
            chk($sformatf("rty_lerr_%0d", k), 32'(link_err), (k == 3) ? 32'd1 : 32'd0);
            if (k < 3) cyc();
        end
        cyc();
        chk("rty_lerr_pulse", 32'(link_err), 32'd0);
        chk("rty_req_idle", 32'(tx_req), 32'd0);
        chk("rty_circle", 32'(circle), 32'(25'd1 << pos_of(3)));

        // Ack on second attempt
        arm();
        sb_q.push_back('{SEL_NUM, 5'd4});
        enter_bcd(8'h04);
        check_msg("rty2");
        for (int j = 0; j < 7; j++) cyc();
        chk("rty2_last", 32'(tx_req), 32'd1);
        cyc();
        chk("rty2_gap", 32'(tx_req), 32'd0);
        cyc();
        chk("rty2_resend", 32'(tx_req), 32'd1);
        chk("rty2_num", 32'(tx_number), 32'd4);
        ack_guess("rty2");
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
